// File: rtl/spi_dda_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_dda_ctrl_if
// SPI bus bundle between a host (master) and spi_dda_ctrl (slave).
//   sclk : SPI clock, driven by the host, asynchronous to the system clock
//   cs_n : chip select, active-low, driven by the host
//   mosi : host-to-device serial data
//   miso : device-to-host serial data
// -----------------------------------------------------------------------------
interface spi_dda_ctrl_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs_n, output mosi, input miso);
   modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_dda_ctrl.sv
// -----------------------------------------------------------------------------
// spi_dda_ctrl
// SPI (mode 0, MSB first, 32-bit frames) control port for a Van der Pol DDA.
// Frame layout: [31:24] cmd, [23:16] ignored, [15:0] data. Commands execute on
// the synchronized cs_n rise of a frame of exactly 32 bits. During a frame the
// current {x,y} state is shifted out on miso.
// Ports:
//   clk, rst_n         : system clock, synchronous active-low reset
//   spi (slave)        : sclk / cs_n / mosi in, miso out
//   x, y               : current DDA state (read back over SPI)
//   mu, icx, icy       : parameter and initial-condition registers
//   load_ic            : one-cycle strobe to load the initial conditions
//   dda_en             : one-cycle DDA step strobe
//   busy               : stepping in progress
//   frame_err          : sticky bad-frame-length flag
// -----------------------------------------------------------------------------
module spi_dda_ctrl #(
   parameter int N        = 16,
   parameter int STEP_GAP = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_dda_ctrl_if.slave spi,
   input  logic [N-1:0]  x,
   input  logic [N-1:0]  y,
   output logic [N-1:0]  mu,
   output logic [N-1:0]  icx,
   output logic [N-1:0]  icy,
   output logic          load_ic,
   output logic          dda_en,
   output logic          busy,
   output logic          frame_err
);

   typedef enum logic {IDLE, SHIFT} rx_state_t;
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} st_state_t;

   localparam logic [15:0] GAP_INIT = (STEP_GAP > 0) ? 16'(STEP_GAP - 1) : '0;

   logic [2:0]  sclk_sync_q, cs_sync_q, sync_vld_q;
   logic [1:0]  mosi_sync_q;
   rx_state_t   rx_state_q, rx_state_d;
   st_state_t   st_state_q, st_state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] shadow_q, shadow_d;
   logic [N-1:0] mu_q, mu_d, icx_q, icx_d, icy_q, icy_d;
   logic        load_ic_q, load_ic_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] steps_left_q, steps_left_d;
   logic [15:0] gap_q, gap_d;

   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic        step_go, ic_go;
   logic [7:0]  cmd;
   logic [15:0] data;

   assign cmd  = shift_q[31:24];
   assign data = shift_q[15:0];

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   // A fall only counts once cs_sync_q[2] holds a post-reset sample, so a
   // cs_n still low when reset releases cannot start a frame mid-transfer.
   assign cs_fall   = sync_vld_q[2] & cs_sync_q[2] & ~cs_sync_q[1];

   // Receiver / command decode
   always_comb begin
      rx_state_d  = rx_state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      shadow_d    = shadow_q;
      mu_d        = mu_q;
      icx_d       = icx_q;
      icy_d       = icy_q;
      load_ic_d   = 1'b0;
      frame_err_d = frame_err_q;
      step_go     = 1'b0;
      ic_go       = 1'b0;
      case (rx_state_q)
         IDLE: begin
            if (cs_fall) begin
               rx_state_d = SHIFT;
               bit_cnt_d  = '0;
               shadow_d   = 32'({x, y});
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               rx_state_d = IDLE;
               if (bit_cnt_q == 6'd32) begin
                  case (cmd)
                     8'h01: mu_d  = N'(data);
                     8'h02: icx_d = N'(data);
                     8'h03: icy_d = N'(data);
                     8'h04: begin
                        load_ic_d = 1'b1;
                        ic_go     = 1'b1;
                     end
                     8'h05: step_go = (data != '0);
                     8'h07: frame_err_d = 1'b0;
                     default: ;
                  endcase
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (sclk_rise) begin
                  shift_d = {shift_q[30:0], mosi_sync_q[1]};
                  if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
               end
               if (sclk_fall) shadow_d = {shadow_q[30:0], 1'b0};
            end
         end
         default: rx_state_d = IDLE;
      endcase
   end

   // Stepper; a STEP or LOAD_IC command overrides whatever is in progress and
   // suppresses dda_en in its command cycle.
   always_comb begin
      st_state_d   = st_state_q;
      steps_left_d = steps_left_q;
      gap_d        = gap_q;
      dda_en       = 1'b0;
      if (ic_go) begin
         st_state_d   = S_IDLE;
         steps_left_d = '0;
      end else if (step_go) begin
         st_state_d   = S_PULSE;
         steps_left_d = data;
      end else begin
         case (st_state_q)
            S_PULSE: begin
               dda_en = 1'b1;
               if (steps_left_q != '0) steps_left_d = steps_left_q - 16'd1;
               if (steps_left_q <= 16'd1) begin
                  st_state_d = S_IDLE;
               end else if (STEP_GAP == 0) begin
                  st_state_d = S_PULSE;
               end else begin
                  st_state_d = S_GAP;
                  gap_d      = GAP_INIT;
               end
            end
            S_GAP: begin
               if (gap_q == '0) st_state_d = S_PULSE;
               else             gap_d = gap_q - 16'd1;
            end
            default: st_state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync_q  <= '0;
         cs_sync_q    <= '1;
         mosi_sync_q  <= '0;
         sync_vld_q   <= '0;
         rx_state_q   <= IDLE;
         st_state_q   <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         shadow_q     <= '0;
         mu_q         <= N'(16'h4000);
         icx_q        <= N'(16'h3000);
         icy_q        <= N'(16'h3000);
         load_ic_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         steps_left_q <= '0;
         gap_q        <= '0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[1:0], spi.sclk};
         cs_sync_q    <= {cs_sync_q[1:0], spi.cs_n};
         mosi_sync_q  <= {mosi_sync_q[0], spi.mosi};
         sync_vld_q   <= {sync_vld_q[1:0], 1'b1};
         rx_state_q   <= rx_state_d;
         st_state_q   <= st_state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         shadow_q     <= shadow_d;
         mu_q         <= mu_d;
         icx_q        <= icx_d;
         icy_q        <= icy_d;
         load_ic_q    <= load_ic_d;
         frame_err_q  <= frame_err_d;
         steps_left_q <= steps_left_d;
         gap_q        <= gap_d;
      end
   end

   assign spi.miso  = (rx_state_q == SHIFT) ? shadow_q[31] : 1'b0;
   assign mu        = mu_q;
   assign icx       = icx_q;
   assign icy       = icy_q;
   assign load_ic   = load_ic_q;
   assign frame_err = frame_err_q;
   assign busy      = (st_state_q != S_IDLE);

endmodule
